// File: rtl/charbuf_pkg.sv
// Shared widths, default buffer size and fill-engine state encoding for the
// character-buffer write path.
package charbuf_pkg;

   localparam int ADDR_W               = 11;
   localparam int DATA_W               = 32;
   localparam int DEFAULT_CHARBUF_SIZE = 1200;

   typedef enum logic [1:0] {
      FILL_IDLE = 2'd0,
      FILL_FILL = 2'd1,
      FILL_DONE = 2'd2
   } fill_state_e;

endpackage

// File: rtl/charbuf_sync_fifo.sv
// Synchronous FIFO with a registered occupancy count; the head entry is
// visible on rdata_o whenever the FIFO is not empty.
module charbuf_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 43,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/charbuf_write_arbiter.sv
// Merges buffered CPU stores and a block-fill engine onto the single
// character-buffer write port, round-robin when both are pending.
module charbuf_write_arbiter
   import charbuf_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int CHARBUF_SIZE = DEFAULT_CHARBUF_SIZE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_wr_en,
   input  logic [ADDR_W-1:0] cpu_wr_addr,
   input  logic [DATA_W-1:0] cpu_wr_data,
   output logic              cpu_stall,
   input  logic              fill_start,
   input  logic [ADDR_W-1:0] fill_base,
   input  logic [ADDR_W-1:0] fill_len,
   input  logic [DATA_W-1:0] fill_data,
   output logic              fill_busy,
   output logic              fill_done,
   output logic              overflow,
   output logic              charbuf_wr_enable,
   output logic [ADDR_W-1:0] charbuf_wr_addr,
   output logic [DATA_W-1:0] charbuf_wr_input
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W:0] SIZE_X = (ADDR_W + 1)'(CHARBUF_SIZE);

   fill_state_e       state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d, len_q, len_d, offset_q, offset_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              prio_fill_q, prio_fill_d;
   logic              overflow_q, overflow_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic                     cpu_in_range, fifo_push, fifo_full, fifo_empty;
   logic [CNT_W-1:0]         fifo_count;
   logic [ADDR_W+DATA_W-1:0] fifo_head;
   logic                     cpu_req, fill_req, gnt_cpu, gnt_fill;
   logic [ADDR_W:0]          base_ext, fill_sum;
   logic [ADDR_W-1:0]        fill_addr;

   assign cpu_in_range = ({1'b0, cpu_wr_addr} < SIZE_X);
   assign fifo_push    = cpu_wr_en && cpu_in_range && !fifo_full;
   assign cpu_stall    = (fifo_count == CNT_W'(FIFO_DEPTH));

   charbuf_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADDR_W + DATA_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (fifo_push),
      .pop_i   (gnt_cpu),
      .wdata_i ({cpu_wr_addr, cpu_wr_data}),
      .rdata_o (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Request/grant: a requester holds its request until granted; at most one
   // grant per cycle, and the pointer moves only when both were requesting.
   assign cpu_req  = !fifo_empty;
   assign fill_req = (state_q == FILL_FILL);
   assign gnt_cpu  = cpu_req && (!fill_req || !prio_fill_q);
   assign gnt_fill = fill_req && (!cpu_req || prio_fill_q);

   assign base_ext  = {1'b0, fill_base};
   assign fill_sum  = {1'b0, base_q} + {1'b0, offset_q};
   assign fill_addr = ADDR_W'((fill_sum >= SIZE_X) ? fill_sum - SIZE_X : fill_sum);

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      data_d    = data_q;
      offset_d  = offset_q;
      fill_busy = 1'b0;
      fill_done = 1'b0;
      case (state_q)
         FILL_IDLE: begin
            if (fill_start) begin
               base_d   = ADDR_W'((base_ext >= SIZE_X) ? base_ext - SIZE_X : base_ext);
               len_d    = fill_len;
               data_d   = fill_data;
               offset_d = '0;
               state_d  = (fill_len != '0) ? FILL_FILL : FILL_DONE;
            end
         end
         FILL_FILL: begin
            fill_busy = 1'b1;
            if (gnt_fill) begin
               if (offset_q == len_q - ADDR_W'(1)) state_d = FILL_DONE;
               else                                offset_d = offset_q + ADDR_W'(1);
            end
         end
         FILL_DONE: begin
            fill_busy = 1'b1;
            fill_done = 1'b1;
            state_d   = FILL_IDLE;
         end
         default: state_d = FILL_IDLE;
      endcase
   end

   always_comb begin
      prio_fill_d = (cpu_req && fill_req) ? gnt_cpu : prio_fill_q;
      overflow_d  = overflow_q || (cpu_wr_en && cpu_in_range && fifo_full);
      wr_en_d     = gnt_cpu || gnt_fill;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      if (gnt_cpu) begin
         wr_addr_d = fifo_head[ADDR_W+DATA_W-1:DATA_W];
         wr_data_d = fifo_head[DATA_W-1:0];
      end else if (gnt_fill) begin
         wr_addr_d = fill_addr;
         wr_data_d = data_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= FILL_IDLE;
         base_q      <= '0;
         len_q       <= '0;
         data_q      <= '0;
         offset_q    <= '0;
         prio_fill_q <= 1'b0;
         overflow_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         data_q      <= data_d;
         offset_q    <= offset_d;
         prio_fill_q <= prio_fill_d;
         overflow_q  <= overflow_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign overflow          = overflow_q;
   assign charbuf_wr_enable = wr_en_q;
   assign charbuf_wr_addr   = wr_addr_q;
   assign charbuf_wr_input  = wr_data_q;

endmodule

// File: tb/tb_charbuf_write_arbiter.sv
// Scenario bench for charbuf_write_arbiter: CPU path, fill wrap, round-robin,
// stall/overflow, zero-length fill and reset mid-fill.
module tb_charbuf_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_wr_en;
   logic [10:0] cpu_wr_addr;
   logic [31:0] cpu_wr_data;
   logic        cpu_stall;
   logic        fill_start;
   logic [10:0] fill_base;
   logic [10:0] fill_len;
   logic [31:0] fill_data;
   logic        fill_busy;
   logic        fill_done;
   logic        overflow;
   logic        charbuf_wr_enable;
   logic [10:0] charbuf_wr_addr;
   logic [31:0] charbuf_wr_input;

   int checks = 0;
   int errors = 0;
   int out_count = 0;
   logic [42:0] cpu_q[$];
   logic [42:0] fill_q[$];
   bit          src_log[$];
   logic [42:0] mon_got;

   charbuf_write_arbiter dut (
      .clk               (clk),
      .reset             (reset),
      .cpu_wr_en         (cpu_wr_en),
      .cpu_wr_addr       (cpu_wr_addr),
      .cpu_wr_data       (cpu_wr_data),
      .cpu_stall         (cpu_stall),
      .fill_start        (fill_start),
      .fill_base         (fill_base),
      .fill_len          (fill_len),
      .fill_data         (fill_data),
      .fill_busy         (fill_busy),
      .fill_done         (fill_done),
      .overflow          (overflow),
      .charbuf_wr_enable (charbuf_wr_enable),
      .charbuf_wr_addr   (charbuf_wr_addr),
      .charbuf_wr_input  (charbuf_wr_input)
   );

   always #5 clk = ~clk;

   // Every write strobe must match the head of the CPU or the fill queue.
   always @(negedge clk) begin
      if (!reset && charbuf_wr_enable) begin
         mon_got = {charbuf_wr_addr, charbuf_wr_input};
         checks++;
         out_count++;
         if (cpu_q.size() != 0 && cpu_q[0] == mon_got) begin
            void'(cpu_q.pop_front());
            src_log.push_back(1'b0);
         end else if (fill_q.size() != 0 && fill_q[0] == mon_got) begin
            void'(fill_q.pop_front());
            src_log.push_back(1'b1);
         end else begin
            errors++;
            $display("FAIL wr_out got addr=%0d data=%h required cpu_head=%h (n=%0d) or fill_head=%h (n=%0d)",
                     charbuf_wr_addr, charbuf_wr_input,
                     (cpu_q.size() != 0) ? cpu_q[0] : 43'h0, cpu_q.size(),
                     (fill_q.size() != 0) ? fill_q[0] : 43'h0, fill_q.size());
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_wr_en   = 1'b0;
      cpu_wr_addr = '0;
      cpu_wr_data = '0;
      fill_start  = 1'b0;
      fill_base   = '0;
      fill_len    = '0;
      fill_data   = '0;
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b1;
      idle_inputs();
      repeat (2) tick();
      cpu_q.delete();
      fill_q.delete();
      src_log.delete();
      out_count = 0;
      reset = 1'b0;
   endtask

   task automatic cpu_write(input logic [10:0] a, input logic [31:0] d, input bit expect_out);
      cpu_wr_en   = 1'b1;
      cpu_wr_addr = a;
      cpu_wr_data = d;
      if (expect_out) cpu_q.push_back({a, d});
   endtask

   task automatic start_fill(input logic [10:0] b, input logic [10:0] l, input logic [31:0] d);
      fill_start = 1'b1;
      fill_base  = b;
      fill_len   = l;
      fill_data  = d;
   endtask

   task automatic wait_drain(input string name);
      bit drained = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (cpu_q.size() == 0 && fill_q.size() == 0 && !fill_busy) begin
            drained = 1'b1;
            break;
         end
         tick();
      end
      repeat (3) tick();
      checks++;
      if (!drained || cpu_q.size() != 0 || fill_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain cpu_left=%0d fill_left=%0d required 0 0", name, cpu_q.size(), fill_q.size());
      end
   endtask

   task automatic test_reset();
      tick();
      reset = 1'b1;
      idle_inputs();
      #1;
      checks++;
      if ({cpu_stall, fill_busy, fill_done, overflow, charbuf_wr_enable, charbuf_wr_addr, charbuf_wr_input} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got stall=%b busy=%b done=%b ovf=%b en=%b addr=%0d data=%h required all 0",
                  cpu_stall, fill_busy, fill_done, overflow, charbuf_wr_enable, charbuf_wr_addr, charbuf_wr_input);
      end
      repeat (2) tick();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({cpu_stall, fill_busy, fill_done, overflow, charbuf_wr_enable} !== 5'b0) begin
         errors++;
         $display("FAIL post_reset_idle got stall=%b busy=%b done=%b ovf=%b en=%b required 0",
                  cpu_stall, fill_busy, fill_done, overflow, charbuf_wr_enable);
      end
   endtask

   task automatic test_cpu_basic();
      do_reset();
      cpu_write(11'd5, 32'h41, 1'b1);
      tick();
      cpu_write(11'd6, 32'h42, 1'b1);
      @(negedge clk);
      checks++;
      if (charbuf_wr_enable !== 1'b0) begin
         errors++;
         $display("FAIL cpu_no_bypass got en=%b required 0", charbuf_wr_enable);
      end
      tick();
      cpu_wr_en = 1'b0;
      @(negedge clk);
      checks++;
      if (charbuf_wr_enable !== 1'b1 || charbuf_wr_addr !== 11'd5) begin
         errors++;
         $display("FAIL cpu_first_plus2 got en=%b addr=%0d required 1 5", charbuf_wr_enable, charbuf_wr_addr);
      end
      tick();
      @(negedge clk);
      checks++;
      if (charbuf_wr_enable !== 1'b1 || charbuf_wr_addr !== 11'd6) begin
         errors++;
         $display("FAIL cpu_second_plus3 got en=%b addr=%0d required 1 6", charbuf_wr_enable, charbuf_wr_addr);
      end
      tick();
      @(negedge clk);
      checks++;
      if (charbuf_wr_enable !== 1'b0 || charbuf_wr_addr !== 11'd6 || charbuf_wr_input !== 32'h42) begin
         errors++;
         $display("FAIL cpu_hold got en=%b addr=%0d data=%h required 0 6 00000042",
                  charbuf_wr_enable, charbuf_wr_addr, charbuf_wr_input);
      end
      wait_drain("cpu_basic");
   endtask

   task automatic test_fill_wrap();
      do_reset();
      start_fill(11'd1198, 11'd4, 32'h20);
      fill_q.push_back({11'd1198, 32'h20});
      fill_q.push_back({11'd1199, 32'h20});
      fill_q.push_back({11'd0, 32'h20});
      fill_q.push_back({11'd1, 32'h20});
      tick();
      fill_start = 1'b0;
      @(negedge clk);
      checks++;
      if (fill_busy !== 1'b1 || fill_done !== 1'b0) begin
         errors++;
         $display("FAIL fill_busy_start got busy=%b done=%b required 1 0", fill_busy, fill_done);
      end
      tick();
      start_fill(11'd10, 11'd3, 32'h99);
      tick();
      fill_start = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      checks++;
      if (fill_done !== 1'b1 || fill_busy !== 1'b1 || charbuf_wr_addr !== 11'd1) begin
         errors++;
         $display("FAIL fill_done_pulse got done=%b busy=%b last_addr=%0d required 1 1 1",
                  fill_done, fill_busy, charbuf_wr_addr);
      end
      tick();
      @(negedge clk);
      checks++;
      if (fill_done !== 1'b0 || fill_busy !== 1'b0 || charbuf_wr_enable !== 1'b0) begin
         errors++;
         $display("FAIL fill_after_done got done=%b busy=%b en=%b required 0 0 0",
                  fill_done, fill_busy, charbuf_wr_enable);
      end
      wait_drain("fill_wrap");
      start_fill(11'd1250, 11'd2, 32'h7);
      fill_q.push_back({11'd50, 32'h7});
      fill_q.push_back({11'd51, 32'h7});
      tick();
      fill_start = 1'b0;
      wait_drain("fill_base_mod");
   endtask

   task automatic test_alternate();
      do_reset();
      start_fill(11'd100, 11'd4, 32'hF0F0);
      for (int i = 0; i < 4; i++) fill_q.push_back({11'(100 + i), 32'hF0F0});
      tick();
      fill_start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cpu_write(11'(500 + k), 32'hC000 + 32'(k), 1'b1);
         tick();
      end
      cpu_wr_en = 1'b0;
      wait_drain("alternate");
      checks++;
      if (src_log.size() != 10) begin
         errors++;
         $display("FAIL alt_count got %0d writes required 10", src_log.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            checks++;
            if (src_log[i] !== ((i < 8) && (i % 2 == 0))) begin
               errors++;
               $display("FAIL alt_order slot %0d got fill=%b required %b", i, src_log[i], (i < 8) && (i % 2 == 0));
            end
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      start_fill(11'd300, 11'd20, 32'hAA);
      for (int i = 0; i < 20; i++) fill_q.push_back({11'(300 + i), 32'hAA});
      tick();
      fill_start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cpu_write(11'(700 + k), 32'hB00 + 32'(k), k < 7);
         checks++;
         if (cpu_stall !== (k == 7)) begin
            errors++;
            $display("FAIL stall_write%0d got stall=%b required %b", k, cpu_stall, k == 7);
         end
         tick();
      end
      cpu_wr_en = 1'b0;
      @(negedge clk);
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_set got %b required 1", overflow);
      end
      wait_drain("stall");
      checks++;
      if (overflow !== 1'b1 || out_count != 27) begin
         errors++;
         $display("FAIL overflow_sticky got ovf=%b writes=%0d required 1 27", overflow, out_count);
      end
   endtask

   task automatic test_zero_len();
      do_reset();
      start_fill(11'd5, 11'd0, 32'h1);
      tick();
      fill_start = 1'b0;
      @(negedge clk);
      checks++;
      if (fill_done !== 1'b1 || fill_busy !== 1'b1 || charbuf_wr_enable !== 1'b0) begin
         errors++;
         $display("FAIL zero_len_done got done=%b busy=%b en=%b required 1 1 0", fill_done, fill_busy, charbuf_wr_enable);
      end
      tick();
      @(negedge clk);
      checks++;
      if (fill_done !== 1'b0 || fill_busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_len_idle got done=%b busy=%b required 0 0", fill_done, fill_busy);
      end
      tick();
      cpu_write(11'd1500, 32'hDEAD, 1'b0);
      tick();
      cpu_write(11'd1200, 32'hDEAD, 1'b0);
      tick();
      cpu_write(11'd1199, 32'hBEEF, 1'b1);
      tick();
      cpu_wr_en = 1'b0;
      wait_drain("zero_len");
      checks++;
      if (overflow !== 1'b0 || out_count != 1) begin
         errors++;
         $display("FAIL out_of_range got ovf=%b writes=%0d required 0 1", overflow, out_count);
      end
   endtask

   task automatic test_reset_midfill();
      bit done_seen = 1'b0;
      do_reset();
      start_fill(11'd400, 11'd10, 32'h55);
      fill_q.push_back({11'd400, 32'h55});
      fill_q.push_back({11'd401, 32'h55});
      tick();
      fill_start = 1'b0;
      tick();
      tick();
      cpu_write(11'd900, 32'h77, 1'b0);
      tick();
      cpu_wr_en = 1'b0;
      reset = 1'b1;
      #1;
      checks++;
      if ({charbuf_wr_enable, charbuf_wr_addr, charbuf_wr_input, fill_busy, fill_done, cpu_stall, overflow} !== '0) begin
         errors++;
         $display("FAIL async_reset got en=%b addr=%0d data=%h busy=%b done=%b required all 0",
                  charbuf_wr_enable, charbuf_wr_addr, charbuf_wr_input, fill_busy, fill_done);
      end
      checks++;
      if (fill_q.size() != 0) begin
         errors++;
         $display("FAIL pre_reset_cells got %0d missing required 0", fill_q.size());
      end
      repeat (2) tick();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (fill_done) done_seen = 1'b1;
      end
      checks++;
      if (done_seen || out_count != 2) begin
         errors++;
         $display("FAIL abort_no_done got done_seen=%b writes=%0d required 0 2", done_seen, out_count);
      end
      tick();
      start_fill(11'd10, 11'd3, 32'h66);
      for (int i = 0; i < 3; i++) fill_q.push_back({11'(10 + i), 32'h66});
      tick();
      fill_start = 1'b0;
      done_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (fill_done) begin
            done_seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!done_seen) begin
         errors++;
         $display("FAIL refill_done got no pulse in 20 cycles required pulse");
      end
      wait_drain("refill");
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_cpu_basic();
      test_fill_wrap();
      test_alternate();
      test_stall();
      test_zero_len();
      test_reset_midfill();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
